// File: rtl/conv_window_builder.sv
// conv_window_builder: raster pixel stream -> flattened 5x5 windows for the convolution ALU.
//   clk, rst_n            : clock, asynchronous active-low reset
//   pix_in/pix_sof        : pixel byte and start-of-frame marker, qualified by pix_valid
//   pix_valid/pix_ready   : input handshake
//   win_flat              : 5x5 window, element r*5+c at bits [(r*5+c)*8 +: 8], r=0 oldest row
//   win_valid/win_ready   : output handshake
//   frame_done            : one-cycle pulse after the last pixel of a frame is accepted
//   win_row/win_col       : top-left coordinate of the window (only with CONV_WIN_COORD_EN)
module conv_window_builder #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   pix_in,
  input  logic         pix_sof,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [199:0] win_flat,
  output logic         win_valid,
  input  logic         win_ready,
  output logic         frame_done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [7:0]   win_row,
  output logic [7:0]   win_col
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [7:0] COL_LAST = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_HEIGHT - 1);
  logic [7:0]   col_q, col_d, row_q, row_d, col_e, row_e;
  logic [199:0] win_q, win_d;
  logic         win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic         pix_acc, emit;
  logic [7:0]   lb_q [4][IMG_WIDTH];
  logic [7:0]   col_pix [5];
  logic [CW-1:0] lb_idx;
`ifdef CONV_WIN_COORD_EN
  logic [7:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif
  assign pix_ready  = rst_n && (!win_valid_q || win_ready);
  assign pix_acc    = pix_valid && pix_ready;
  assign win_flat   = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  always_comb begin
    // a start-of-frame pixel is always (0,0), whatever the counters say
    col_e  = pix_sof ? '0 : col_q;
    row_e  = pix_sof ? '0 : row_q;
    lb_idx = col_e[CW-1:0];
    col_pix[0] = lb_q[3][lb_idx];
    col_pix[1] = lb_q[2][lb_idx];
    col_pix[2] = lb_q[1][lb_idx];
    col_pix[3] = lb_q[0][lb_idx];
    col_pix[4] = pix_in;
    emit  = pix_acc && row_e >= 8'd4 && col_e >= 8'd4;
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (pix_acc) begin
      col_d = (col_e == COL_LAST) ? '0 : col_e + 8'd1;
      row_d = (col_e != COL_LAST) ? row_e : (row_e == ROW_LAST) ? '0 : row_e + 8'd1;
      // each window row shifts one column left; the new column enters at c=4 (top bits)
      for (int r = 0; r < 5; r++) win_d[r*40 +: 40] = {col_pix[r], win_q[r*40+8 +: 32]};
    end
    // the window register only moves on pix_acc, which is blocked while a window is held
    win_valid_d  = emit || (win_valid_q && !win_ready);
    frame_done_d = pix_acc && row_e == ROW_LAST && col_e == COL_LAST;
`ifdef CONV_WIN_COORD_EN
    win_row_d = emit ? row_e - 8'd4 : win_row_q;
    win_col_d = emit ? col_e - 8'd4 : win_col_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CONV_WIN_COORD_EN
      win_row_q    <= '0;
      win_col_q    <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef CONV_WIN_COORD_EN
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
`endif
    end
  end
  // line buffers hold no reset: stale rows are never emitted
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb_q[3][lb_idx] <= lb_q[2][lb_idx];
      lb_q[2][lb_idx] <= lb_q[1][lb_idx];
      lb_q[1][lb_idx] <= lb_q[0][lb_idx];
      lb_q[0][lb_idx] <= pix_in;
    end
  end
endmodule

// File: tb/tb_conv_window_builder.sv
// tb_conv_window_builder: self-checking bench with an image-array reference model.
module tb_conv_window_builder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] p5 = '0, p6 = '0;
  logic sof5 = 0, v5 = 0, wr5 = 0, sof6 = 0, v6 = 0, wr6 = 0;
  logic r5, wv5, fd5, r6, wv6, fd6;
  logic [199:0] wf5, wf6;
  int n_chk = 0;
  int n_fail = 0;
`ifdef CONV_WIN_COORD_EN
  logic [7:0] wrow5, wcol5, wrow6, wcol6;
`endif
  conv_window_builder #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) u5 (
    .clk(clk), .rst_n(rst_n), .pix_in(p5), .pix_sof(sof5), .pix_valid(v5), .pix_ready(r5),
    .win_flat(wf5), .win_valid(wv5), .win_ready(wr5), .frame_done(fd5)
`ifdef CONV_WIN_COORD_EN
    , .win_row(wrow5), .win_col(wcol5)
`endif
  );
  conv_window_builder #(.IMG_WIDTH(6), .IMG_HEIGHT(6)) u6 (
    .clk(clk), .rst_n(rst_n), .pix_in(p6), .pix_sof(sof6), .pix_valid(v6), .pix_ready(r6),
    .win_flat(wf6), .win_valid(wv6), .win_ready(wr6), .frame_done(fd6)
`ifdef CONV_WIN_COORD_EN
    , .win_row(wrow6), .win_col(wcol6)
`endif
  );
  task automatic test_reset;
    #2;
    n_chk++;
    if ({wv6, fd6, r6, wv5, fd5, r5} !== 6'b0 || wf6 !== '0 || wf5 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wv6=%b fd6=%b r6=%b wv5=%b fd5=%b r5=%b required all 0", wv6, fd6, r6, wv5, fd5, r5);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (r6 !== 1'b1 || r5 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got r6=%b r5=%b required 1", r6, r5);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_5x5(input bit alt);
    logic [7:0] e;
    wr5 = 1'b1;
    v5 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      p5 = alt ? ((i % 2) ? 8'hFF : 8'h80) : 8'(i);
      sof5 = (i == 0);
      @(negedge clk);
      n_chk++;
      if (r5 !== 1'b1 || wv5 !== 1'b0 || fd5 !== 1'b0) begin
        n_fail++;
        $display("FAIL 5x5_stream px%0d: got ready=%b valid=%b done=%b required 1 0 0", i, r5, wv5, fd5);
      end
      @(posedge clk);
      #1;
    end
    v5 = 1'b0;
    sof5 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (wv5 !== 1'b1 || fd5 !== 1'b1) begin
      n_fail++;
      $display("FAIL 5x5_window_done: got valid=%b done=%b required 1 1", wv5, fd5);
    end
    for (int i = 0; i < 25; i++) begin
      e = alt ? ((i % 2) ? 8'hFF : 8'h80) : 8'(i);
      n_chk++;
      if (wf5[i*8 +: 8] !== e) begin
        n_fail++;
        $display("FAIL 5x5_elem%0d: got %02h required %02h", i, wf5[i*8 +: 8], e);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if (wv5 !== 1'b0 || fd5 !== 1'b0) begin
      n_fail++;
      $display("FAIL 5x5_after: got valid=%b done=%b required 0 0", wv5, fd5);
    end
    @(posedge clk);
    #1;
  endtask
  // mode 0: always valid/ready; 1: random gaps on both sides; 2: first window stalled 10 cycles
  task automatic stream(input int n, input bit sof0, input int sof_mid, input int mode,
                        input bit ramp, input int exp_win);
    logic [7:0] img [6][6];
    logic [199:0] q [$];
    logic [199:0] w;
    int sent = 0, r = 0, c = 0, nwin = 0, stalls = 0, cyc = 0;
    bit exp_fd = 0;
    bit acc;
    while ((sent < n || q.size() != 0 || exp_fd) && cyc < 3000) begin
      cyc++;
      v6 = (sent < n) && (mode != 1 || $urandom_range(3) != 0);
      p6 = ramp ? 8'(sent) : 8'($urandom);
      sof6 = (sent == 0 && sof0) || (sent == sof_mid);
      wr6 = (mode == 2) ? !(nwin == 0 && stalls < 10) : (mode == 0 || $urandom_range(2) != 0);
      @(negedge clk);
      n_chk++;
      if (r6 !== (!wv6 || wr6)) begin
        n_fail++;
        $display("FAIL pix_ready: got %b required %b", r6, !wv6 || wr6);
      end
      n_chk++;
      if (wv6 !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL win_valid: got %b required %b", wv6, q.size() != 0);
      end
      if (wv6 === 1'b1 && q.size() != 0) begin
        n_chk++;
        if (wf6 !== q[0]) begin
          n_fail++;
          $display("FAIL win_flat win%0d: got %h required %h", nwin, wf6, q[0]);
        end
      end
      n_chk++;
      if (fd6 !== exp_fd) begin
        n_fail++;
        $display("FAIL frame_done: got %b required %b", fd6, exp_fd);
      end
      if (wv6 && !wr6) stalls++;
      if (wv6 && wr6 && q.size() != 0) begin
        void'(q.pop_front());
        nwin++;
      end
      acc = v6 && r6;
      exp_fd = 0;
      if (acc) begin
        if (sof6) begin
          r = 0;
          c = 0;
        end
        img[r][c] = p6;
        if (r >= 4 && c >= 4) begin
          for (int i = 0; i < 25; i++) w[i*8 +: 8] = img[r-4+i/5][c-4+i%5];
          q.push_back(w);
        end
        exp_fd = (r == 5 && c == 5);
        sent++;
        if (c == 5) begin
          c = 0;
          r = (r == 5) ? 0 : r + 1;
        end else c++;
      end
      @(posedge clk);
      #1;
    end
    v6 = 1'b0;
    sof6 = 1'b0;
    wr6 = 1'b1;
    n_chk++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d cycles required under 3000", cyc);
    end
    n_chk++;
    if (nwin != exp_win) begin
      n_fail++;
      $display("FAIL window_count: got %0d required %0d", nwin, exp_win);
    end
    if (mode == 2) begin
      n_chk++;
      if (stalls != 10) begin
        n_fail++;
        $display("FAIL stall_cycles: got %0d required 10", stalls);
      end
    end
    @(negedge clk);
    n_chk++;
    if (wv6 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: got %b required 0", wv6);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_ramp;
    stream(36, 1'b1, -1, 0, 1'b1, 4);
  endtask
  task automatic test_backpressure;
    stream(36, 1'b1, -1, 2, 1'b0, 4);
  endtask
  task automatic test_back_to_back;
    stream(72, 1'b1, -1, 1, 1'b0, 8);
  endtask
  task automatic test_sof_abort;
    stream(53, 1'b1, 17, 1, 1'b0, 4);
  endtask
  task automatic test_reset_mid;
    wr6 = 1'b0;
    v6 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      p6 = 8'(k);
      sof6 = (k == 0);
      @(posedge clk);
      #1;
    end
    sof6 = 1'b0;
    n_chk++;
    if (wv6 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_window: got %b required 1", wv6);
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (wv6 !== 1'b0 || fd6 !== 1'b0 || r6 !== 1'b0 || wf6 !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b done=%b ready=%b flat=%h required all 0", wv6, fd6, r6, wf6);
    end
    v6 = 1'b0;
    wr6 = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    stream(36, 1'b0, -1, 1, 1'b0, 4);
  endtask
  initial begin
    test_reset;
    test_5x5(1'b0);
    test_5x5(1'b1);
    test_ramp;
    test_backpressure;
    test_back_to_back;
    test_sof_abort;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
